// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the GPU shared-memory crossbar.
// Provides default widths, the bank/word address split helpers and the
// flat-bus slice helper used to pick core i out of a concatenated port.
package gpu_mem_pkg;

  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_N_BANKS   = 16;
  localparam int DEF_BANK_BITS = $clog2(DEF_N_BANKS);

  // Bank field: the top bank_bits of an addr_w-wide address.
  function automatic logic [31:0] bank_of(input logic [31:0] addr,
                                          input int unsigned addr_w,
                                          input int unsigned bank_bits);
    logic [31:0] mask;
    mask = (32'd1 << bank_bits) - 32'd1;
    return (addr >> (addr_w - bank_bits)) & mask;
  endfunction

  // Word field: everything below the bank field.
  function automatic logic [31:0] word_of(input logic [31:0] addr,
                                          input int unsigned addr_w,
                                          input int unsigned bank_bits);
    logic [31:0] mask;
    mask = (32'd1 << (addr_w - bank_bits)) - 32'd1;
    return addr & mask;
  endfunction

  // Low bit of element idx in a flat bus of w-bit elements.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/shared_mem_xbar_rr_arbiter.sv
// Round-robin arbiter for one bank.
// Ports: req_i  - requesting cores
//        ptr_i  - current priority pointer (first index considered)
//        gnt_o  - one-hot grant (all zero when nobody requests)
//        ptr_o  - next pointer: one past the winner, or ptr_i when idle
module rr_arbiter #(
  parameter int N  = 16,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] ptr_o
);

  // Scan from ptr_i upward with wrap; first requester wins.
  always_comb begin
    int  idx;
    logic found;
    gnt_o = '0;
    ptr_o = ptr_i;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr_i) + off;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        ptr_o      = PW'((idx + 1) % N);
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/shared_mem_xbar.sv
// Shared-memory crossbar: N_CORES load/store ports onto N_BANKS banks with
// per-bank round-robin arbitration, plus a non-blocking display read port.
// Ports: clk/reset (async, active-low); req_ld/req_st/addr/wdata per core
// (flat, core i at slice i); rdata/finish per core (registered, finish is a
// one-cycle pulse); disp_addr -> disp_data (1-cycle); conflict_cnt saturating.
module shared_mem_xbar
  import gpu_mem_pkg::*;
#(
  parameter int N_CORES = 16,
  parameter int N_BANKS = DEF_N_BANKS,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          req_ld,
  input  logic [N_CORES-1:0]          req_st,
  input  logic [N_CORES*ADDR_W-1:0]   addr,
  input  logic [N_CORES*DATA_W-1:0]   wdata,
  output logic [N_CORES*DATA_W-1:0]   rdata,
  output logic [N_CORES-1:0]          finish,
  input  logic [ADDR_W-1:0]           disp_addr,
  output logic [DATA_W-1:0]           disp_data,
  output logic [CNT_W-1:0]            conflict_cnt
);

  localparam int BANK_BITS = $clog2(N_BANKS);
  localparam int WORD_W    = ADDR_W - BANK_BITS;
  localparam int WORDS     = 1 << WORD_W;
  localparam int PTR_W     = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  if ((N_BANKS < 2) || ((N_BANKS & (N_BANKS - 1)) != 0)) begin : g_bad_param
    $error("shared_mem_xbar: N_BANKS must be a power of two >= 2");
  end

  logic [N_CORES-1:0]        elig_s, cgnt_s;
  logic [BANK_BITS-1:0]      cbank_s [N_CORES];
  logic [WORD_W-1:0]         cword_s [N_CORES];
  logic [N_CORES-1:0]        bgnt_s  [N_BANKS];
  logic [DATA_W-1:0]         brd_s   [N_BANKS];
  logic [DATA_W-1:0]         bdisp_s [N_BANKS];
  logic [PTR_W-1:0]          ptr_q   [N_BANKS];
  logic [PTR_W-1:0]          ptr_d   [N_BANKS];
  logic [BANK_BITS-1:0]      disp_bank_s;
  logic [WORD_W-1:0]         disp_word_s;
  logic                      conflict_s;

  logic [N_CORES-1:0]        finish_q, finish_d;
  logic [N_CORES*DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0]         disp_q, disp_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  // Per-core address split and eligibility; a core seeing its own finish is
  // masked so a still-held request is not granted twice.
  always_comb begin
    logic [ADDR_W-1:0] caddr;
    caddr  = '0;
    elig_s = (req_ld | req_st) & ~finish_q;
    for (int i = 0; i < N_CORES; i++) begin
      caddr      = addr[slice_lo(i, ADDR_W) +: ADDR_W];
      cbank_s[i] = BANK_BITS'(bank_of(32'(caddr), ADDR_W, BANK_BITS));
      cword_s[i] = WORD_W'(word_of(32'(caddr), ADDR_W, BANK_BITS));
    end
    disp_bank_s = BANK_BITS'(bank_of(32'(disp_addr), ADDR_W, BANK_BITS));
    disp_word_s = WORD_W'(word_of(32'(disp_addr), ADDR_W, BANK_BITS));
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0]  mem_q [WORDS];
    logic [N_CORES-1:0] breq_s;
    logic [WORD_W-1:0]  bword_s;
    logic               bwe_s;
    logic [DATA_W-1:0]  bwdata_s;

    // Requests targeting this bank.
    always_comb begin
      breq_s = '0;
      for (int i = 0; i < N_CORES; i++) begin
        breq_s[i] = elig_s[i] && (cbank_s[i] == BANK_BITS'(b));
      end
    end

    rr_arbiter #(.N(N_CORES), .PW(PTR_W)) u_arb (
      .req_i (breq_s),
      .ptr_i (ptr_q[b]),
      .gnt_o (bgnt_s[b]),
      .ptr_o (ptr_d[b])
    );

    // Mux the winner's word/data onto the core port. A store wins over a
    // simultaneous load; writes are suppressed while reset is held so an
    // in-flight grant is fully dropped.
    always_comb begin
      bword_s  = '0;
      bwe_s    = 1'b0;
      bwdata_s = '0;
      for (int i = 0; i < N_CORES; i++) begin
        if (bgnt_s[b][i]) begin
          bword_s  = cword_s[i];
          bwe_s    = req_st[i] & reset;
          bwdata_s = wdata[slice_lo(i, DATA_W) +: DATA_W];
        end else begin
        end
      end
    end

    // Bank storage: core write port; contents survive reset.
    always_ff @(posedge clk) begin
      if (bwe_s) begin
        mem_q[bword_s] <= bwdata_s;
      end
    end

    // Both read ports see the pre-write value in the write cycle.
    assign brd_s[b]   = mem_q[bword_s];
    assign bdisp_s[b] = mem_q[disp_word_s];
  end

  // Next-state for core responses, display read and conflict counter.
  always_comb begin
    cgnt_s = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      cgnt_s = cgnt_s | bgnt_s[b];
    end
    finish_d = cgnt_s;
    rdata_d  = rdata_q;
    for (int i = 0; i < N_CORES; i++) begin
      if (cgnt_s[i] && !req_st[i]) begin
        rdata_d[slice_lo(i, DATA_W) +: DATA_W] = brd_s[cbank_s[i]];
      end else begin
      end
    end
    disp_d     = bdisp_s[disp_bank_s];
    conflict_s = |(elig_s & ~cgnt_s);
    if (conflict_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output and pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      finish_q <= '0;
      rdata_q  <= '0;
      disp_q   <= '0;
      cnt_q    <= '0;
      for (int b = 0; b < N_BANKS; b++) begin
        ptr_q[b] <= '0;
      end
    end else begin
      finish_q <= finish_d;
      rdata_q  <= rdata_d;
      disp_q   <= disp_d;
      cnt_q    <= cnt_d;
      for (int b = 0; b < N_BANKS; b++) begin
        ptr_q[b] <= ptr_d[b];
      end
    end
  end

  assign finish       = finish_q;
  assign rdata        = rdata_q;
  assign disp_data    = disp_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: doc/shared_mem_xbar.md
Name: shared_mem_xbar

Overview:
- Parametrised shared-memory interconnect that replaces the fixed 16-core x 16-bank arbiter array and the OR-reduced finish/data buses at the GPU top level.
- Routes N_CORES load/store requests to N_BANKS single-word-per-cycle banks using per-bank round-robin arbitration.
- Returns per-core read data with a one-cycle finish pulse.
- Provides an independent display read port (VGA) and a saturating bank-conflict counter.

Parameters:
N_CORES, 16, number of requesting cores
N_BANKS, 16, number of banks; power of two, >=2
ADDR_W, 12, core/display address width; bank = addr[ADDR_W-1 -: log2(N_BANKS)], word = remaining low bits
DATA_W, 8, data word width
CNT_W, 16, conflict counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_ld  in  N_CORES  per-core load request, level, held until finish
req_st  in  N_CORES  per-core store request, level, held until finish
addr  in  N_CORES*ADDR_W  per-core address, core i at slice i
wdata  in  N_CORES*DATA_W  per-core store data
rdata  out  N_CORES*DATA_W  per-core load data, registered
finish  out  N_CORES  one-cycle completion pulse per core
disp_addr  in  ADDR_W  display read address
disp_data  out  DATA_W  display read data, registered
conflict_cnt  out  CNT_W  saturating count of conflict cycles

Behaviour:
- Reset (reset low, async): finish=0, rdata=0, disp_data=0, conflict_cnt=0, all RR pointers=0. Bank contents are not cleared.
- Reset asserted mid-operation: in-flight grants are dropped and no finish is issued for them.
- Eligibility in cycle t: core i is eligible if (req_ld[i]|req_st[i]) and finish[i]==0. The finish mask prevents re-grant while the core is still seeing its own completion.
- Arbitration, per bank b, each cycle: among eligible cores whose bank field == b, grant the first core index at or after ptr[b], wrapping modulo N_CORES.
  - On grant to core k: ptr[b] <= (k+1) mod N_CORES.
  - With no requesters, ptr[b] holds.
- Store granted in cycle t: bank word written at the end of t. finish[k]=1 during t+1. rdata[k] is unchanged.
- Load granted in cycle t: bank word read at the end of t. rdata[k] is valid and finish[k]=1 during t+1. rdata[k] then holds until the next completed load by core k.
- req_ld and req_st both high: treated as a store.
- Latency: 1 cycle from grant to finish. Peak rate is one access per core per 2 cycles and one access per bank per cycle.
- Distinct banks: all banks grant independently in the same cycle.
- Same-word store (core) and display read in the same cycle: disp_data returns the old value.
- Display port: disp_data <= bank[disp_addr] every cycle, 1-cycle latency. It never stalls and never blocks cores; each bank is dual-ported (core port + display read port).
- conflict_cnt: +1 in any cycle in which at least one eligible request was not granted. Saturates at 2^CNT_W-1.
- Out-of-range parameters (N_BANKS not a power of two): elaboration error.

Decomposition:
- Package gpu_mem_pkg:
  - default widths (ADDR_W, DATA_W)
  - BANK_BITS = log2(N_BANKS)
  - bank_of()/word_of() address-split functions
  - core slice index helpers
- Sub-module rr_arbiter #(N): request vector + pointer in; one-hot grant + next pointer out. One instance per bank.
- Bank storage stays inline as a generate loop of arrays; the core port is written and read, the display port is read-only.

Test Plan:
1. Reset, then core 3 stores 0xA5 to addr 0x205, then loads 0x205 -> finish[3] pulses one cycle after each grant; rdata[3]=0xA5; conflict_cnt=0.
2. Cores 0,1,2 all load bank 4 simultaneously, held -> grants in order 0,1,2 on consecutive cycles; finish pulses at t+1, t+2, t+3; ptr[4]=3 afterward; conflict_cnt=2.
3. 16 cores each access a distinct bank in the same cycle -> all 16 finish pulses in the same cycle; conflict_cnt unchanged.
4. Core 5 stores 0x3C to 0x100 while disp_addr=0x100 in the same cycle -> disp_data shows old value next cycle and 0x3C the cycle after.
5. Core 7 asserts req_ld and req_st to 0x0FF with wdata 0x11 -> executed as a store; a later load returns 0x11; rdata[7] unchanged by the dual request.
6. Assert reset during a cycle with a granted load -> no finish pulse; all outputs 0; after release, a re-issued request from core 0 is granted first (pointer reset).
